// File: rtl/xsleena_sdr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xsleena_sdr_pkg
// Purpose  : Shared types and constants for the SDRAM read arbiter: FSM state
//            encoding, requester indices and the round-robin wrap helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package xsleena_sdr_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [1:0] REQ_OBJ = 2'd0;
  localparam logic [1:0] REQ_BG1 = 2'd1;
  localparam logic [1:0] REQ_BG2 = 2'd2;

  // Requester index following idx, wrapping bg2 back to obj.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= REQ_BG2) ? REQ_OBJ : idx + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xsleena_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : xsleena_rr_pick
// Purpose  : Combinational round-robin choice among the three requesters.
//            The search starts at ptr and moves upward with wrap-around.
// Ports    : pending[2:0] - requesters with a queued read
//            ptr[1:0]     - index searched first
//            valid        - at least one requester pending
//            grant[1:0]   - chosen requester index
// Revision : 1.0 - initial release
// ============================================================================
module xsleena_rr_pick
  import xsleena_sdr_pkg::*;
(
  input  logic [2:0] pending,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] grant
);

  logic [1:0] w_cand [3];

  // Search order ptr, ptr+1, ptr+2 (mod 3); an out-of-range ptr acts as obj.
  assign w_cand[0] = (ptr > REQ_BG2) ? REQ_OBJ : ptr;
  assign w_cand[1] = rr_next(w_cand[0]);
  assign w_cand[2] = rr_next(w_cand[1]);

  // Walk from the lowest priority candidate upward so the first candidate
  // in search order is the last one written.
  always_comb begin
    valid = 1'b0;
    grant = REQ_OBJ;
    for (int k = 2; k >= 0; k--) begin
      if (pending[w_cand[k]]) begin
        valid = 1'b1;
        grant = w_cand[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/xsleena_sdr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : xsleena_sdr_arbiter
// Purpose  : Round-robin arbiter sharing one SDRAM read port among three
//            requesters (obj, bg1, bg2). Each requester may queue one read;
//            one transaction is in flight at a time, with a timeout that
//            returns all-ones data and sets a sticky error flag.
// Ports    : CLK, RSTn          - clock, asynchronous active-low reset
//            req[2:0], addr     - one-cycle read pulses and their addresses
//            rdy[2:0], dout     - per-requester data-valid pulse and data
//            mem_addr, mem_rd   - read address and strobe to SDRAM controller
//            mem_rdy, mem_dout  - read completion pulse and data
//            busy, err          - transaction in flight, sticky timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module xsleena_sdr_arbiter
  import xsleena_sdr_pkg::*;
#(
  parameter int AW      = 25,
  parameter int DW      = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic [2:0]         req,
  input  logic [2:0][AW-1:0] addr,
  output logic [2:0]         rdy,
  output logic [2:0][DW-1:0] dout,
  output logic [AW-1:0]      mem_addr,
  output logic               mem_rd,
  input  logic               mem_rdy,
  input  logic [DW-1:0]      mem_dout,
  output logic               busy,
  output logic               err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        r_state;
  logic [2:0]    r_pend;
  logic [1:0]    r_ptr;
  logic [1:0]    r_gnt;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_req_addr [3];

  logic          w_valid;
  logic [1:0]    w_pick;
  logic          w_issue;
  logic [2:0]    w_clr;
  logic [CW-1:0] w_cnt_inc;

  // Address capture per requester; a repeated req simply overwrites.
  generate
    for (genvar i = 0; i < 3; i++) begin : g_req_addr
      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
          r_req_addr[i] <= '0;
        end else if (req[i]) begin
          r_req_addr[i] <= addr[i];
        end
      end
    end
  endgenerate

  xsleena_rr_pick u_rr_pick (
    .pending (r_pend),
    .ptr     (r_ptr),
    .valid   (w_valid),
    .grant   (w_pick)
  );

  assign w_issue   = (r_state == IDLE) && w_valid;
  assign w_clr     = w_issue ? (3'b001 << w_pick) : 3'b000;
  assign w_cnt_inc = r_cnt + CW'(1);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state  <= IDLE;
      r_pend   <= '0;
      r_ptr    <= REQ_OBJ;
      r_gnt    <= REQ_OBJ;
      r_cnt    <= '0;
      rdy      <= '0;
      dout     <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      rdy    <= '0;
      // A new req wins over the grant clear, so a request from the requester
      // being granted on this very edge is queued rather than lost.
      r_pend <= (r_pend & ~w_clr) | req;

      case (r_state)
        IDLE: begin
          if (w_valid) begin
            mem_addr <= r_req_addr[w_pick];
            mem_rd   <= 1'b1;
            r_gnt    <= w_pick;
            r_ptr    <= rr_next(w_pick);
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rdy) begin
            dout[r_gnt] <= mem_dout;
            rdy[r_gnt]  <= 1'b1;
            busy        <= 1'b0;
            r_state     <= IDLE;
          end else if (w_cnt_inc == CW'(TIMEOUT)) begin
            dout[r_gnt] <= '1;
            rdy[r_gnt]  <= 1'b1;
            err         <= 1'b1;
            busy        <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xsleena_sdr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_xsleena_sdr_arbiter
// Purpose  : Self-checking bench for xsleena_sdr_arbiter: directed scenarios
//            plus randomized traffic against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xsleena_sdr_arbiter;

  localparam int AW = 25;
  localparam int DW = 16;
  localparam int TO = 7;

  typedef struct {
    int            cyc;
    int            idx;
    logic [AW-1:0] a;
  } rq_t;

  logic               CLK = 1'b0;
  logic               RSTn;
  logic [2:0]         req;
  logic [2:0][AW-1:0] addr;
  logic [2:0]         rdy;
  logic [2:0][DW-1:0] dout;
  logic [AW-1:0]      mem_addr;
  logic               mem_rd;
  logic               mem_rdy;
  logic [DW-1:0]      mem_dout;
  logic               busy;
  logic               err;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  xsleena_sdr_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .req      (req),
    .addr     (addr),
    .rdy      (rdy),
    .dout     (dout),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_rdy  (mem_rdy),
    .mem_dout (mem_dout),
    .busy     (busy),
    .err      (err)
  );

  task automatic do_reset();
    req = '0; addr = '0; mem_rdy = 1'b0; mem_dout = '0;
    @(negedge CLK); RSTn = 1'b0;
    @(negedge CLK);
    @(negedge CLK); RSTn = 1'b1;
  endtask

  task automatic test_reset();
    total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    total++; if (rdy !== 3'b000) begin bad++; $display("FAIL reset_rdy: got %b want 000", rdy); end
    total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    total++; if (dout !== '0) begin bad++; $display("FAIL reset_dout: got %h want 0", dout); end
  endtask

  // Simultaneous requests straight out of reset: obj, bg1, bg2 in order.
  task automatic test_all_three();
    logic [AW-1:0] a [3];
    logic [DW-1:0] d [3];
    int t;
    for (int i = 0; i < 3; i++) begin
      a[i] = AW'($urandom); d[i] = DW'($urandom);
    end
    @(negedge CLK); req = 3'b111;
    for (int i = 0; i < 3; i++) addr[i] = a[i];
    @(negedge CLK); req = 3'b000;
    for (int n = 0; n < 3; n++) begin
      t = 0;
      while (mem_rd !== 1'b1 && t < 8) begin @(negedge CLK); t++; end
      total++; if (mem_rd !== 1'b1) begin bad++; $display("FAIL all3_issue%0d: mem_rd got %b want 1 within 8 cycles", n, mem_rd); end
      total++; if (mem_addr !== a[n]) begin bad++; $display("FAIL all3_addr%0d: got %h want %h", n, mem_addr, a[n]); end
      repeat ($urandom_range(0, 4)) @(negedge CLK);
      mem_rdy = 1'b1; mem_dout = d[n];
      @(negedge CLK); mem_rdy = 1'b0;
      total++; if (rdy !== 3'(1 << n)) begin bad++; $display("FAIL all3_rdy%0d: got %b want %b", n, rdy, 3'(1 << n)); end
      total++; if (dout[n] !== d[n]) begin bad++; $display("FAIL all3_dout%0d: got %h want %h", n, dout[n], d[n]); end
    end
  endtask

  task automatic test_single_obj();
    @(negedge CLK); req = 3'b001; addr[0] = 25'h0012345;
    @(negedge CLK); req = 3'b000;
    total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL single_early_rd: got %b want 0", mem_rd); end
    @(negedge CLK);
    total++; if (mem_rd !== 1'b1) begin bad++; $display("FAIL single_rd: got %b want 1", mem_rd); end
    total++; if (mem_addr !== 25'h0012345) begin bad++; $display("FAIL single_addr: got %h want 0012345", mem_addr); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
    @(negedge CLK); @(negedge CLK); @(negedge CLK);
    total++; if (mem_addr !== 25'h0012345 || mem_rd !== 1'b0) begin bad++; $display("FAIL single_hold: addr %h rd %b want 0012345/0", mem_addr, mem_rd); end
    mem_rdy = 1'b1; mem_dout = 16'hBEEF;
    @(negedge CLK); mem_rdy = 1'b0;
    total++; if (rdy !== 3'b001) begin bad++; $display("FAIL single_rdy: got %b want 001", rdy); end
    total++; if (dout[0] !== 16'hBEEF) begin bad++; $display("FAIL single_dout: got %h want beef", dout[0]); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: busy got %b want 0", busy); end
    @(negedge CLK);
    total++; if (rdy !== 3'b000 || dout[0] !== 16'hBEEF) begin bad++; $display("FAIL single_after: rdy %b dout %h want 000/beef", rdy, dout[0]); end
  endtask

  // bg2 re-requests while queued behind obj: only the newer address is read.
  task automatic test_overwrite();
    int n_rd, n_rdy2;
    logic [AW-1:0] seen;
    n_rd = 0; n_rdy2 = 0; seen = '0;
    @(negedge CLK); req = 3'b001; addr[0] = 25'h0000ABC;
    @(negedge CLK); req = 3'b000;
    @(negedge CLK);
    total++; if (mem_rd !== 1'b1 || mem_addr !== 25'h0000ABC) begin bad++; $display("FAIL ovw_obj_issue: rd %b addr %h want 1/0000abc", mem_rd, mem_addr); end
    req = 3'b100; addr[2] = 25'h100;
    @(negedge CLK); req = 3'b100; addr[2] = 25'h200;
    @(negedge CLK); req = 3'b000; mem_rdy = 1'b1; mem_dout = 16'h5A5A;
    @(negedge CLK); mem_rdy = 1'b0;
    total++; if (rdy !== 3'b001) begin bad++; $display("FAIL ovw_obj_rdy: got %b want 001", rdy); end
    for (int j = 0; j < 10; j++) begin
      @(negedge CLK);
      mem_rdy = 1'b0;
      if (rdy[2] === 1'b1) n_rdy2++;
      if (mem_rd === 1'b1) begin
        n_rd++; seen = mem_addr; mem_rdy = 1'b1; mem_dout = 16'h0202;
      end
    end
    mem_rdy = 1'b0;
    total++; if (n_rd !== 1) begin bad++; $display("FAIL ovw_count: mem_rd pulses got %0d want 1", n_rd); end
    total++; if (seen !== 25'h200) begin bad++; $display("FAIL ovw_addr: got %h want 0000200", seen); end
    total++; if (n_rdy2 !== 1 || dout[2] !== 16'h0202) begin bad++; $display("FAIL ovw_bg2_data: rdy pulses %0d dout %h want 1/0202", n_rdy2, dout[2]); end
  endtask

  // Random traffic checked against a transaction-level model: a request
  // becomes visible to arbitration two cycles after it is driven, one read is
  // outstanding at a time, and grants follow round-robin order.
  task automatic test_traffic(input int ncyc, input bit obj_hold);
    rq_t           evq [$];
    rq_t           ev;
    bit            pend [3];
    logic [AW-1:0] paddr [3];
    logic [DW-1:0] dref [3];
    logic [AW-1:0] issued;
    logic [DW-1:0] rdy_data;
    logic [2:0]    exp_rdy;
    logic [2:0]    r;
    int            origin, gnt, g, c, mstart, lat, free_at, rdy_at;
    bit            mbusy, exp_rd;
    do_reset();
    origin = 0; gnt = 0; g = 0; mstart = 0; lat = 0; free_at = 0; rdy_at = -1;
    mbusy = 1'b0; issued = '0; rdy_data = '0;
    for (int i = 0; i < 3; i++) begin pend[i] = 1'b0; paddr[i] = '0; dref[i] = '0; end
    for (int k = 0; k < ncyc + 40; k++) begin
      @(negedge CLK);
      while (evq.size() > 0 && evq[0].cyc <= k - 2) begin
        ev = evq.pop_front();
        pend[ev.idx] = 1'b1;
        paddr[ev.idx] = ev.a;
      end
      exp_rdy = 3'b000;
      if (rdy_at == k) begin exp_rdy[gnt] = 1'b1; dref[gnt] = rdy_data; end
      total++; if (rdy !== exp_rdy) begin bad++; $display("FAIL traffic_rdy c%0d: got %b want %b", k, rdy, exp_rdy); end
      for (int i = 0; i < 3; i++) begin
        total++; if (dout[i] !== dref[i]) begin bad++; $display("FAIL traffic_dout%0d c%0d: got %h want %h", i, k, dout[i], dref[i]); end
      end
      exp_rd = 1'b0;
      if (!mbusy && k >= free_at) begin
        for (int o = 0; o < 3; o++) begin
          c = (origin + o) % 3;
          if (!exp_rd && pend[c]) begin exp_rd = 1'b1; g = c; end
        end
      end
      total++; if (mem_rd !== exp_rd) begin bad++; $display("FAIL traffic_mem_rd c%0d: got %b want %b", k, mem_rd, exp_rd); end
      if (exp_rd) begin
        pend[g] = 1'b0; issued = paddr[g]; gnt = g; mbusy = 1'b1; mstart = k;
        lat = $urandom_range(0, 5); origin = (g + 1) % 3;
      end
      if (mbusy) begin
        total++; if (mem_addr !== issued) begin bad++; $display("FAIL traffic_mem_addr c%0d: got %h want %h", k, mem_addr, issued); end
      end
      total++; if (busy !== mbusy) begin bad++; $display("FAIL traffic_busy c%0d: got %b want %b", k, busy, mbusy); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL traffic_err c%0d: got %b want 0", k, err); end
      mem_rdy = 1'b0; mem_dout = DW'($urandom);
      if (mbusy) begin
        if (k == mstart + lat) begin
          mem_rdy = 1'b1; rdy_at = k + 1; rdy_data = mem_dout; mbusy = 1'b0; free_at = k + 2;
        end
      end else begin
        mem_rdy = ($urandom_range(0, 3) == 0);
      end
      r = 3'b000;
      if (k < ncyc) begin
        for (int i = 0; i < 3; i++) r[i] = ($urandom_range(0, 3) == 0);
        if (obj_hold) r[0] = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
        addr[i] = AW'($urandom);
        if (r[i]) evq.push_back('{k, i, addr[i]});
      end
      req = r;
    end
    req = '0; mem_rdy = 1'b0;
  endtask

  task automatic test_timeout();
    int t;
    @(negedge CLK); req = 3'b001; addr[0] = AW'($urandom);
    @(negedge CLK); req = 3'b000;
    t = 0;
    while (mem_rd !== 1'b1 && t < 8) begin @(negedge CLK); t++; end
    total++; if (mem_rd !== 1'b1) begin bad++; $display("FAIL to_issue: mem_rd got %b want 1 within 8 cycles", mem_rd); end
    for (int j = 0; j < TO; j++) begin
      total++; if (busy !== 1'b1 || rdy !== 3'b000) begin bad++; $display("FAIL to_wait%0d: busy %b rdy %b want 1/000", j, busy, rdy); end
      @(negedge CLK);
    end
    total++; if (rdy !== 3'b001) begin bad++; $display("FAIL to_rdy: got %b want 001", rdy); end
    total++; if (dout[0] !== 16'hFFFF) begin bad++; $display("FAIL to_dout: got %h want ffff", dout[0]); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_idle: busy got %b want 0", busy); end
    // A normal bg1 read afterwards: err stays set, obj data untouched.
    @(negedge CLK); req = 3'b010; addr[1] = 25'h0BEEF;
    @(negedge CLK); req = 3'b000;
    @(negedge CLK); mem_rdy = 1'b1; mem_dout = 16'h1111;
    @(negedge CLK); mem_rdy = 1'b0;
    total++; if (rdy !== 3'b010 || dout[1] !== 16'h1111) begin bad++; $display("FAIL to_next: rdy %b dout1 %h want 010/1111", rdy, dout[1]); end
    total++; if (err !== 1'b1 || dout[0] !== 16'hFFFF) begin bad++; $display("FAIL to_sticky: err %b dout0 %h want 1/ffff", err, dout[0]); end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK); req = 3'b001; addr[0] = 25'h0001234;
    @(negedge CLK); req = 3'b000;
    @(negedge CLK);
    @(negedge CLK);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy: got %b want 1", busy); end
    RSTn = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || mem_rd !== 1'b0 || rdy !== 3'b000) begin bad++; $display("FAIL rmid_ctrl: busy %b rd %b rdy %b want 0/0/000", busy, mem_rd, rdy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rmid_err: got %b want 0", err); end
    total++; if (mem_addr !== '0 || dout !== '0) begin bad++; $display("FAIL rmid_data: addr %h dout %h want 0/0", mem_addr, dout); end
    @(negedge CLK);
    @(negedge CLK); RSTn = 1'b1;
    @(negedge CLK); mem_rdy = 1'b1; mem_dout = 16'h7777;
    @(negedge CLK); mem_rdy = 1'b0;
    for (int j = 0; j < 3; j++) begin
      total++; if (rdy !== 3'b000 || busy !== 1'b0 || dout !== '0) begin bad++; $display("FAIL rmid_late%0d: rdy %b busy %b dout %h want 000/0/0", j, rdy, busy, dout); end
      @(negedge CLK);
    end
    req = 3'b010; addr[1] = 25'h1ABCDEF;
    @(negedge CLK); req = 3'b000;
    @(negedge CLK);
    total++; if (mem_rd !== 1'b1 || mem_addr !== 25'h1ABCDEF) begin bad++; $display("FAIL rmid_next_issue: rd %b addr %h want 1/1abcdef", mem_rd, mem_addr); end
    @(negedge CLK); mem_rdy = 1'b1; mem_dout = 16'hC0DE;
    @(negedge CLK); mem_rdy = 1'b0;
    total++; if (rdy !== 3'b010 || dout[1] !== 16'hC0DE) begin bad++; $display("FAIL rmid_next_rdy: rdy %b dout1 %h want 010/c0de", rdy, dout[1]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RSTn = 1'b0; req = '0; addr = '0; mem_rdy = 1'b0; mem_dout = '0;
    repeat (3) @(negedge CLK);
    test_reset();
    RSTn = 1'b1;
    test_all_three();
    test_single_obj();
    test_overwrite();
    test_traffic(300, 1'b0);
    test_traffic(300, 1'b1);
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xsleena_sdr_arbiter.md
XSLEENA_SDR_ARBITER -- requirements
Module: xsleena_sdr_arbiter

Interface
REQ-001 SHALL have parameter AW, default 25, meaning SDRAM word address width.
REQ-002 SHALL have parameter DW, default 16, meaning SDRAM data width.
REQ-003 SHALL have parameter TIMEOUT, default 1023, meaning the maximum number of CLK cycles spent waiting for mem_rdy.
REQ-004 SHALL have port CLK, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port RSTn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req, input, 3, one-cycle read request pulses; bit 0 = obj, bit 1 = bg1, bit 2 = bg2.
REQ-007 SHALL have port addr, input, 3 x AW, requester addresses, sampled in the cycle of the matching req bit.
REQ-008 SHALL have port rdy, output, 3, one-cycle per-requester data-valid pulses.
REQ-009 SHALL have port dout, output, 3 x DW, per-requester read data.
REQ-010 SHALL have port mem_addr, output, AW, address to the SDRAM controller.
REQ-011 SHALL have port mem_rd, output, 1, one-cycle read strobe to the SDRAM controller.
REQ-012 SHALL have port mem_rdy, input, 1, one-cycle SDRAM read-complete pulse.
REQ-013 SHALL have port mem_dout, input, DW, SDRAM read data, valid while mem_rdy = 1.
REQ-014 SHALL have port busy, output, 1, high while a transaction is in flight.
REQ-015 SHALL have port err, output, 1, sticky timeout flag.

Function
REQ-016 SHALL latch each req pulse into a per-requester pending bit plus an address register on the same edge.
REQ-017 SHALL overwrite the latched address when req repeats while that requester is pending but not yet issued; only one request per requester is queued.
REQ-018 SHALL implement FSM states IDLE and WAIT.
REQ-019 SHALL, in IDLE with any pending bit set, pick one requester per REQ-020 and, on that edge: drive mem_addr from the chosen address register, pulse mem_rd for one cycle, clear the chosen pending bit, and enter WAIT.
REQ-020 SHALL select by round-robin, searching upward with wrap-around starting from the index after the last grant; the pointer resets to 0, so obj wins the first contest.
REQ-021 SHALL hold mem_addr stable from the mem_rd edge until leaving WAIT.
REQ-022 SHALL, in WAIT on mem_rdy, register mem_dout into dout of the granted requester, pulse its rdy on the next cycle, and return to IDLE.
REQ-023 SHALL have a minimum latency of 2 cycles from req to mem_rd when idle, and 1 cycle from mem_rdy to rdy.
REQ-024 SHALL hold each dout value until that requester's next rdy; other requesters' dout SHALL be unaffected.
REQ-025 SHALL capture a req from the granted requester that arrives during WAIT, or on the same edge it is granted, as a new pending request; no request is lost.
REQ-026 SHALL count WAIT cycles with a counter of width clog2(TIMEOUT+1). When the count reaches TIMEOUT without mem_rdy, it SHALL set dout of the granted requester to all-ones, pulse its rdy, set err, and return to IDLE.
REQ-027 SHALL ignore mem_rdy while in IDLE.
REQ-028 SHALL drive busy = 1 exactly while in WAIT.
REQ-029 SHALL clear err only by reset.

Reset
REQ-030 SHALL, while RSTn = 0, asynchronously force: state IDLE, pending bits 0, round-robin pointer 0, timeout counter 0, rdy 0, mem_rd 0, busy 0, err 0, mem_addr 0, and all dout 0.
REQ-031 SHALL, on reset assertion mid-transaction, abandon the transaction with no rdy pulse; any mem_rdy arriving after release SHALL be ignored per REQ-027.

Structure
REQ-032 SHALL place in shared package xsleena_sdr_pkg: the state enum (IDLE, WAIT) and requester index constants (REQ_OBJ = 0, REQ_BG1 = 1, REQ_BG2 = 2).
REQ-033 SHALL implement the round-robin choice as combinational sub-module xsleena_rr_pick, with inputs pending[2:0] and ptr[1:0], and outputs valid and grant index.

Verification
REQ-034 SHALL cover: single obj req, addr 0x0012345, mem_rdy 3 cycles after mem_rd with data 0xBEEF -> mem_rd 2 cycles after req with mem_addr 0x0012345; rdy[0] 1 cycle after mem_rdy with dout[0] = 0xBEEF.
REQ-035 SHALL cover: req = 3'b111 in one cycle after reset -> grant order obj, bg1, bg2, each with its own address and data; exactly one rdy bit per transaction.
REQ-036 SHALL cover: obj requesting continuously during bg1 and bg2 traffic -> no requester waits more than 2 grants; pointer wraps from bg2 to obj.
REQ-037 SHALL cover: bg2 req twice while pending (addr 0x100, then 0x200) -> single mem_rd at 0x200.
REQ-038 SHALL cover: mem_rdy withheld with TIMEOUT = 7 -> rdy pulse after 7 WAIT cycles, dout = 0xFFFF, err = 1 and stays 1 until RSTn low.
REQ-039 SHALL cover: RSTn low during WAIT, then late mem_rdy -> all outputs 0 and no rdy; next req is served normally.
